// File: rtl/uart_word_bridge.sv
// -----------------------------------------------------------------------------
// uart_word_bridge
//
// Host-side serial bridge for the RF block, entirely on the RF clock domain.
//   RX half: UART bytes from the host are packed big-endian into 32-bit words
//            and offered on a valid/ready word port.
//   TX half: bytes taken from a valid/ready byte port are serialised onto
//            uart_tx.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
//   TIMEOUT_BITS  idle bit-times after which a partial word is discarded
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   uart_rx           serial input (asynchronous, idle high)
//   uart_tx           serial output (idle high)
//   byte_in_*         byte source for the transmitter (ready = TX idle)
//   word_out_*        assembled word towards the RF controller
//   frame_err         1-cycle pulse: bad stop bit (or bad parity)
//   overrun           1-cycle pulse: received byte dropped, word path full
//
// Build option:
//   UART_BRIDGE_PARITY_EN  when defined, an even-parity bit follows bit 7 on
//                          TX and is checked on RX (8E1). Otherwise 8N1.
// -----------------------------------------------------------------------------
module uart_word_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  input  logic [7:0]  byte_in_data,
  input  logic        byte_in_valid,
  output logic        byte_in_ready,
  output logic [31:0] word_out_data,
  output logic        word_out_valid,
  input  logic        word_out_ready,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_BITS);

`ifdef UART_BRIDGE_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_BRIDGE_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } uart_state_t;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  uart_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_q, tx_d;
  logic            tx_ready_q, tx_ready_d;

  // TX state register plus bit timer, bit index and latched byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_byte_q  <= 8'h00;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // TX next-state: every non-idle state lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = 3'd0;
        if (byte_in_valid) begin
          tx_state_d = ST_START;
          tx_byte_d  = byte_in_data;
        end else begin
          tx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) begin
`ifdef UART_BRIDGE_PARITY_EN
            tx_state_d = ST_PARITY;
`else
            tx_state_d = ST_STOP;
`endif
          end else begin
            tx_state_d = ST_DATA;
          end
        end else begin
          tx_state_d = ST_DATA;
        end
      end
`ifdef UART_BRIDGE_PARITY_EN
      ST_PARITY: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_STOP;
        end else begin
          tx_state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_IDLE;
        end else begin
          tx_state_d = ST_STOP;
        end
      end
      default: begin
        tx_cnt_d   = '0;
        tx_state_d = ST_IDLE;
      end
    endcase
  end

  // TX outputs, decoded from the next state so the line and ready are registered.
  always_comb begin
    tx_d       = 1'b1;
    tx_ready_d = (tx_state_d == ST_IDLE);
    case (tx_state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = tx_byte_d[tx_bit_d];
`ifdef UART_BRIDGE_PARITY_EN
      ST_PARITY: tx_d = even_parity(tx_byte_d);
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  logic            rx_fall_s;
  uart_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_perr_q, rx_perr_d;
  logic            rx_byte_ok_s, rx_ferr_s;

  // Two-flop synchroniser; the third flop only feeds falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // A frame-error byte leaves the line low, so no new edge appears until it
  // has gone high again: this is what re-arms the receiver.
  assign rx_fall_s = rx_s3_q & ~rx_s2_q;

  // RX state register plus sample timer, bit index, shifter and parity flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // RX next-state: mid-start check after half a bit, then one sample per bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d  = '0;
        rx_bit_d  = 3'd0;
        rx_perr_d = 1'b0;
        if (rx_fall_s) begin
          rx_state_d = ST_START;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          // Line already high again: a glitch, not a start bit.
          if (rx_s2_q) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_state_d = ST_DATA;
          end
        end else begin
          rx_state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) begin
`ifdef UART_BRIDGE_PARITY_EN
            rx_state_d = ST_PARITY;
`else
            rx_state_d = ST_STOP;
`endif
          end else begin
            rx_state_d = ST_DATA;
          end
        end else begin
          rx_state_d = ST_DATA;
        end
      end
`ifdef UART_BRIDGE_PARITY_EN
      ST_PARITY: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_perr_d  = rx_s2_q ^ even_parity(rx_shift_q);
          rx_state_d = ST_STOP;
        end else begin
          rx_state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
        end else begin
          rx_state_d = ST_STOP;
        end
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = ST_IDLE;
      end
    endcase
  end

  // RX outputs: byte-complete or frame-error strobe at the stop sample.
  always_comb begin
    rx_byte_ok_s = 1'b0;
    rx_ferr_s    = 1'b0;
    if ((rx_state_q == ST_STOP) && (rx_cnt_q == BIT_LAST)) begin
      if (rx_s2_q && !rx_perr_q) begin
        rx_byte_ok_s = 1'b1;
      end else begin
        rx_ferr_s = 1'b1;
      end
    end else begin
      rx_byte_ok_s = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Word assembly, output register and partial-word timeout
  // ---------------------------------------------------------------------------
  logic [31:0]   asm_q, asm_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          held_q, held_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          ferr_q, ovr_q, ovr_d;
  logic [CW-1:0] to_clk_q, to_clk_d;
  logic [TW-1:0] to_bits_q, to_bits_d;
  logic          to_run_s, to_expired_s;
  logic [31:0]   word_full_s;

  // Word path and timeout registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q       <= 32'h0;
      cnt_q       <= 2'd0;
      held_q      <= 1'b0;
      out_data_q  <= 32'h0;
      out_valid_q <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      to_clk_q    <= '0;
      to_bits_q   <= '0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ferr_q      <= rx_ferr_s;
      ovr_q       <= ovr_d;
      to_clk_q    <= to_clk_d;
      to_bits_q   <= to_bits_d;
    end
  end

  // A held (complete) word must never time out, only a partial one.
  assign to_run_s     = (cnt_q != 2'd0) && !held_q && (rx_state_q == ST_IDLE);
  assign to_expired_s = to_run_s && (to_bits_q == TO_LIMIT);
  assign word_full_s  = {asm_q[31:8], rx_shift_q};

  // Bit-time counter; cleared whenever it is not running (any start bit).
  always_comb begin
    if (!to_run_s || to_expired_s) begin
      to_clk_d  = '0;
      to_bits_d = '0;
    end else if (to_clk_q == BIT_LAST) begin
      to_clk_d  = '0;
      to_bits_d = to_bits_q + 1'b1;
    end else begin
      to_clk_d  = to_clk_q + 1'b1;
      to_bits_d = to_bits_q;
    end
  end

  // Byte packing, output register load/hold and overrun detection.
  always_comb begin
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    out_data_d = out_data_q;
    ovr_d      = 1'b0;
    if (out_valid_q && word_out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (held_q) begin
      // Held word moves one cycle after the handshake has emptied the register.
      if (!out_valid_q) begin
        out_data_d  = asm_q;
        out_valid_d = 1'b1;
        held_d      = 1'b0;
        cnt_d       = 2'd0;
      end else begin
        held_d = 1'b1;
      end
      ovr_d = rx_byte_ok_s;
    end else if (rx_byte_ok_s) begin
      if (cnt_q == 2'd3) begin
        if (!out_valid_q || word_out_ready) begin
          out_data_d  = word_full_s;
          out_valid_d = 1'b1;
          cnt_d       = 2'd0;
        end else begin
          asm_d  = word_full_s;
          held_d = 1'b1;
        end
      end else begin
        case (cnt_q)
          2'd0:    asm_d[31:24] = rx_shift_q;
          2'd1:    asm_d[23:16] = rx_shift_q;
          2'd2:    asm_d[15:8]  = rx_shift_q;
          default: asm_d        = asm_q;
        endcase
        cnt_d = cnt_q + 1'b1;
      end
    end else if (to_expired_s) begin
      cnt_d = 2'd0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign uart_tx        = tx_q;
  assign byte_in_ready  = tx_ready_q;
  assign word_out_data  = out_data_q;
  assign word_out_valid = out_valid_q;
  assign frame_err      = ferr_q;
  assign overrun        = ovr_q;

endmodule

// File: doc/uart_word_bridge.md
# uart_word_bridge

Host-side serial bridge for the RF block. The RX half deserialises UART bytes from the host into 32-bit words and presents them on a valid/ready port that drives the RF controller's `Tx_data`/`Tx_valid`/`Tx_ready` port. The TX half pops bytes from the RF receive FIFO over a valid/ready port and serialises them onto `uart_tx`. Everything runs on the RF clock domain; only `uart_rx` is asynchronous.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit, minimum 4.
- `TIMEOUT_BITS`, default 40: idle bit-times after which a partially assembled word is discarded.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `uart_rx`  in  1  serial input, idle high, asynchronous.
- `uart_tx`  out  1  serial output, idle high.
- `byte_in_data`  in  8  byte to transmit (from the RX FIFO `dout`).
- `byte_in_valid`  in  1  byte available.
- `byte_in_ready`  out  1  transmitter idle; a byte is taken when valid and ready are both high.
- `word_out_data`  out  32  assembled word.
- `word_out_valid`  out  1  word available.
- `word_out_ready`  in  1  consumer accepts the word.
- `frame_err`  out  1  one-cycle pulse: bad stop bit, or bad parity when parity is enabled.
- `overrun`  out  1  one-cycle pulse: a received byte was dropped because the word path was full.

## Operation
- Reset values: `uart_tx`=1, `byte_in_ready`=1, `word_out_valid`=0, `word_out_data`=0, `frame_err`=0, `overrun`=0. All counters clear and both FSMs go to IDLE. Reset mid-frame abandons the frame immediately.
- TX FSM: IDLE → START → DATA(8 bits, LSB first) → [PARITY] → STOP → IDLE.
  - `byte_in_ready` is high only in IDLE.
  - The byte is latched on the handshake.
  - Each state holds for CLKS_PER_BIT cycles.
- RX front end: `uart_rx` passes through a 2-flop synchroniser.
- RX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE to START on a synchronised 1→0 transition.
  - START re-samples the line at CLKS_PER_BIT/2 (integer division). If the line is high there, the start was a glitch: return to IDLE with no error.
  - Each later bit is sampled CLKS_PER_BIT cycles after the previous sample.
  - STOP: a sample of 0 (or a parity mismatch) pulses `frame_err` and discards the byte. The FSM then waits for the line to read high before re-arming.
- Word assembly:
  - Bytes are packed big-endian: the first byte lands in [31:24], the fourth in [7:0].
  - A 2-bit byte counter wraps 3→0 when the word is transferred into the output register.
- Output register:
  - Loaded when the 4th byte completes and the register is empty, or is emptied in that same cycle by a handshake.
  - `word_out_valid` stays high and `word_out_data` stays stable until `word_out_ready`.
- Full word path: the 4th byte completes while the output register is still occupied and not being accepted.
  - The 4th byte is held in the assembly buffer.
  - Every further completed byte is dropped, with a `overrun` pulse per drop.
  - The held word moves to the output register in the cycle after the handshake frees it.
- Timeout:
  - A bit-time counter runs while the byte counter is non-zero and RX is IDLE.
  - When it reaches TIMEOUT_BITS, the byte counter clears and the partial bytes are discarded, with no pulse.
  - Any start bit resets the counter.
- TX and RX are fully independent; simultaneous activity has no interaction.

## Timing
- TX: `uart_tx` falls in the cycle after the handshake. A frame lasts 10·CLKS_PER_BIT cycles (11 with parity). `byte_in_ready` rises in the cycle after the last stop-bit cycle.
- RX latency: the byte is complete at the stop-bit sample point, which is 2 synchroniser cycles plus 9.5·CLKS_PER_BIT after the line falls (10.5 with parity). `word_out_valid` rises 1 cycle after the 4th byte's stop sample.
- `frame_err` and `overrun` pulse in the cycle after the stop sample.
- Word handshake: a transfer occurs on the rising edge where valid and ready are both high. Back-to-back words are possible.

## Configuration
- `UART_BRIDGE_PARITY_EN` defined: an even-parity bit is sent after bit 7 on TX. RX checks the parity bit and treats a mismatch as a frame error.
- Undefined: 8N1 framing; the PARITY states are not built.

## Test plan
- CLKS_PER_BIT=8. Send bytes 0xDE, 0xAD, 0xBE, 0xEF on `uart_rx`, `word_out_ready`=1 → one `word_out_valid` pulse with `word_out_data`=0xDEADBEEF; `frame_err`=0.
- `byte_in_data`=0xA5 handshake → `uart_tx` shows 0,1,0,1,0,0,1,0,1,1, 8 cycles per bit. `byte_in_ready` is low for 80 cycles, then high.
- Send 8 bytes 0x01..0x08 with `word_out_ready`=0, then set ready=1 → first word is 0x01020304. The held second word is 0x05060708. Add a 9th byte before release → one `overrun` pulse, and the next word is still 0x05060708.
- Send a byte with the stop bit forced to 0 → `frame_err` pulses once, the byte counter is unchanged, and the next valid frame is received correctly.
- Send 0x11, 0x22, then idle for 41 bit-times, then 0x33, 0x44, 0x55, 0x66 → word is 0x33445566.
- Pulse `uart_rx` low for 2 cycles → no byte and no `frame_err`. Assert `rst` mid-TX-frame → `uart_tx`=1 and `byte_in_ready`=1 immediately.
